// File: rtl/adder_sum_accum.sv
// Collects BLOCK_LEN adder sums into a saturating accumulator and tracks the block maximum.
// One result per valid/ready transfer; out_valid rises the cycle after the final sample is accepted.
module adder_sum_accum #(
   parameter int IN_W      = 5,
   parameter int ACC_W     = 12,
   parameter int BLOCK_LEN = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_sum,
   input  logic             clear,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_acc,
   output logic [IN_W-1:0]  out_max,
   output logic             out_ovf,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

   localparam logic [7:0] LEN = 8'(BLOCK_LEN);

   state_t           state;
   logic [ACC_W-1:0] acc;
   logic [7:0]       count;
   logic [IN_W-1:0]  max_val;
   logic             ovf;

   logic             accept;
   logic [ACC_W:0]   sum_ext;
   logic             sat;
   logic [ACC_W-1:0] acc_nxt;
   logic [IN_W-1:0]  max_nxt;
   logic [7:0]       cnt_nxt;

   assign in_ready = (state != HOLD);
   assign busy     = (state != IDLE);
   assign accept   = in_valid && in_ready;

   always_comb begin
      sum_ext = {1'b0, acc} + {{(ACC_W + 1 - IN_W){1'b0}}, in_sum};
      sat     = sum_ext[ACC_W];
      acc_nxt = sat ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
      max_nxt = (in_sum > max_val) ? in_sum : max_val;
      cnt_nxt = count + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         acc       <= '0;
         count     <= '0;
         max_val   <= '0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
         out_acc   <= '0;
         out_max   <= '0;
         out_ovf   <= 1'b0;
      end else if (clear) begin
         // Abort wins over a same-cycle handshake; out_* keep their last loaded values.
         state     <= IDLE;
         acc       <= '0;
         count     <= '0;
         max_val   <= '0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE, ACCUM: begin
               if (accept) begin
                  acc     <= acc_nxt;
                  max_val <= max_nxt;
                  ovf     <= ovf | sat;
                  count   <= cnt_nxt;
                  if (cnt_nxt == LEN) begin
                     out_acc   <= acc_nxt;
                     out_max   <= max_nxt;
                     out_ovf   <= ovf | sat;
                     out_valid <= 1'b1;
                     state     <= HOLD;
                  end else begin
                     state <= ACCUM;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  acc       <= '0;
                  count     <= '0;
                  max_val   <= '0;
                  ovf       <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adder_sum_accum.sv
// Directed bench for adder_sum_accum: default instance plus a narrow-accumulator instance for saturation.
module tb_adder_sum_accum;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [4:0]  in_sum = '0;
   logic        clear = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [11:0] out_acc;
   logic [4:0]  out_max;
   logic        out_ovf;
   logic        busy;

   logic        in_valid7 = 1'b0;
   logic        in_ready7;
   logic [4:0]  in_sum7 = '0;
   logic        clear7 = 1'b0;
   logic        out_valid7;
   logic        out_ready7 = 1'b1;
   logic [6:0]  out_acc7;
   logic [4:0]  out_max7;
   logic        out_ovf7;
   logic        busy7;

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   adder_sum_accum dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
      .clear(clear), .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
      .out_max(out_max), .out_ovf(out_ovf), .busy(busy)
   );

   adder_sum_accum #(.IN_W(5), .ACC_W(7), .BLOCK_LEN(8)) dut7 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid7), .in_ready(in_ready7), .in_sum(in_sum7),
      .clear(clear7), .out_valid(out_valid7), .out_ready(out_ready7), .out_acc(out_acc7),
      .out_max(out_max7), .out_ovf(out_ovf7), .busy(busy7)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Present one sample for exactly one rising edge; called at a falling edge.
   task automatic send(input logic [4:0] v);
      in_valid = 1'b1;
      in_sum   = v;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic send7(input logic [4:0] v);
      in_valid7 = 1'b1;
      in_sum7   = v;
      @(negedge clk);
      in_valid7 = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      @(negedge clk);
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_acc", out_acc, 0);
      check("rst_out_max", out_max, 0);
      check("rst_out_ovf", out_ovf, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_busy", busy, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic block: 31+0+5+17+2+9+30+1 = 95
      send(31); send(0); send(5); send(17);
      send(2);  send(9); send(30);
      check("basic_no_early_valid", out_valid, 0);
      send(1);
      check("basic_valid", out_valid, 1);
      check("basic_acc", out_acc, 95);
      check("basic_max", out_max, 31);
      check("basic_ovf", out_ovf, 0);
      check("basic_in_ready_hold", in_ready, 0);
      @(negedge clk);
      check("basic_valid_drop", out_valid, 0);
      check("basic_busy_idle", busy, 0);
      check("basic_acc_retained", out_acc, 95);

      // Saturation on the 7-bit instance: 8*31 = 248 -> 127
      for (int i = 0; i < 8; i++) send7(31);
      check("sat_valid", out_valid7, 1);
      check("sat_acc", out_acc7, 127);
      check("sat_ovf", out_ovf7, 1);
      check("sat_max", out_max7, 31);
      @(negedge clk);
      for (int i = 0; i < 8; i++) send7(1);
      check("sat2_acc", out_acc7, 8);
      check("sat2_ovf", out_ovf7, 0);
      check("sat2_max", out_max7, 1);
      @(negedge clk);
      check("sat2_idle", busy7, 0);

      // Backpressure: block of 3s (acc 24), then a 4 held against a stalled result
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) send(3);
      in_valid = 1'b1;
      in_sum   = 4;
      for (int i = 0; i < 5; i++) begin
         check("bp_in_ready", in_ready, 0);
         check("bp_valid", out_valid, 1);
         check("bp_acc", out_acc, 24);
         check("bp_max", out_max, 3);
         @(negedge clk);
      end
      out_ready = 1'b1;
      check("bp_raise_in_ready", in_ready, 0);
      @(negedge clk);
      check("bp_handshake", out_valid, 0);
      check("bp_in_ready_after", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      check("bp_held_accepted", busy, 1);
      for (int i = 0; i < 6; i++) send(0);
      check("bp_no_early_valid", out_valid, 0);
      send(0);
      check("bp_next_valid", out_valid, 1);
      check("bp_next_acc", out_acc, 4);
      check("bp_next_max", out_max, 4);
      @(negedge clk);

      // Clear mid-block: 20s and the 9 presented with clear are discarded
      send(20); send(20); send(20);
      in_valid = 1'b1;
      in_sum   = 9;
      clear    = 1'b1;
      @(negedge clk);
      clear    = 1'b0;
      in_valid = 1'b0;
      check("clr_busy", busy, 0);
      for (int i = 0; i < 8; i++) send(1);
      check("clr_valid", out_valid, 1);
      check("clr_acc", out_acc, 8);
      check("clr_max", out_max, 1);
      @(negedge clk);

      // Clear in HOLD overrides a same-cycle out_ready
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) send(2);
      check("hclr_pending", out_valid, 1);
      out_ready = 1'b1;
      clear     = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check("hclr_valid", out_valid, 0);
      check("hclr_busy", busy, 0);
      check("hclr_in_ready", in_ready, 1);
      check("hclr_acc_retained", out_acc, 16);

      // Async reset mid-block, mid-cycle
      for (int i = 0; i < 5; i++) send(7);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_acc", out_acc, 0);
      check("arst_max", out_max, 0);
      check("arst_valid", out_valid, 0);
      check("arst_in_ready", in_ready, 1);
      check("arst_busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 7; i++) send(2);
      check("arst_no_early_valid", out_valid, 0);
      send(2);
      check("arst_valid_after", out_valid, 1);
      check("arst_acc_after", out_acc, 16);
      check("arst_max_after", out_max, 2);
      @(negedge clk);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule

// File: doc/adder_sum_accum.md
Name: adder_sum_accum

Overview:
Downstream consumer of the ADDER result bus. Collects BLOCK_LEN successive adder sums, accumulates them with saturation and tracks the block maximum. Presents one block result per valid/ready handshake to the next stage (cache statistics and checksum logic).

Parameters:
IN_W, 5, width of incoming adder sum (matches ADDER c output).
ACC_W, 12, accumulator and output width; must be >= IN_W.
BLOCK_LEN, 8, samples per block; legal range 2..255.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_sum carries a valid adder result
in_ready  output  1  block can accept a sample this cycle
in_sum  input  IN_W  adder result, unsigned
clear  input  1  synchronous abort of the current block
out_valid  output  1  block result available
out_ready  input  1  downstream accepts the result
out_acc  output  ACC_W  saturated sum of block samples
out_max  output  IN_W  largest sample in block
out_ovf  output  1  saturation occurred in block (sticky per block)
busy  output  1  state != IDLE

Behaviour:
- Reset, async on rst_n low. State is IDLE; accumulator, count, max and ovf are 0; out_valid=0, out_acc=0, out_max=0, out_ovf=0, in_ready=1, busy=0. Reset mid-block discards all partial state.
- FSM states:
  - IDLE: no samples held. On accept -> ACCUM (count=1). If BLOCK_LEN reached on that accept, use the ACCUM->HOLD rule instead.
  - ACCUM: 1..BLOCK_LEN-1 samples held.
  - HOLD: result presented.
- Accept = in_valid && in_ready. in_ready = 1 in IDLE and ACCUM, 0 in HOLD. Combinational from state only, with no dependency on out_ready.
- On accept:
  - acc_next = acc + in_sum, computed at ACC_W+1 bits.
  - If the sum exceeds 2^ACC_W-1, acc = 2^ACC_W-1 and ovf is set to 1.
  - max = larger of max and in_sum.
  - count increments.
- On the accept that makes count == BLOCK_LEN, in the same edge:
  - out_acc, out_max and out_ovf load the final values, including the current sample.
  - out_valid goes to 1 and state -> HOLD.
  - Latency: out_valid is high the cycle after the final accept.
- HOLD:
  - out_* stay stable while out_valid=1 and out_ready=0.
  - On out_valid && out_ready: out_valid goes to 0 and state -> IDLE. acc, count, max and ovf are cleared.
  - out_acc, out_max and out_ovf retain their last values until the next block loads.
  - A sample presented in the handshake cycle is not accepted (in_ready=0). It is accepted the following cycle.
- clear has priority over everything except reset:
  - Any state -> IDLE; acc, count, max and ovf are 0; out_valid=0.
  - A sample presented in the clear cycle is dropped.
  - A result in HOLD is discarded even if out_ready=1 in that cycle; downstream must not treat that cycle as a transfer.
- No combinational path from in_* to out_*. All outputs are registered except in_ready and busy, which decode state.
- Block boundary: count wraps to 0 only via HOLD->IDLE or clear. Samples are never split across blocks.

Test Plan:
1. Basic block: default params, 8 back-to-back samples 31,0,5,17,2,9,30,1, out_ready=1 -> one cycle after the 8th accept: out_valid=1, out_acc=95, out_max=31, out_ovf=0; out_valid drops next cycle, busy=0.
2. Saturation: ACC_W=7, 8 samples of 31 -> out_acc=127, out_ovf=1, out_max=31. The next block of 8 samples of 1 gives out_acc=8, out_ovf=0.
3. Backpressure:
   - Stimulus: after a block completes, hold out_ready=0 for 5 cycles while in_valid=1, in_sum=4; then raise out_ready.
   - Response: in_ready=0 and out_* constant throughout; handshake on the raise cycle.
   - The held sample 4 is accepted the cycle after the handshake, as count 1 of the next block.
4. Clear mid-block: accept 3 samples of 20, pulse clear with in_valid=1, in_sum=9, then feed 8 samples of 1 -> the 9 is dropped; out_acc=8, out_max=1.
5. Clear in HOLD: result pending with out_ready=1 and clear=1 in the same cycle -> out_valid=0 next cycle; state IDLE; no transfer counted.
6. Async reset: assert rst_n=0 mid-clock after 5 accepted samples -> all outputs go to reset values immediately, in_ready=1. After release, a fresh 8-sample block of 2 gives out_acc=16.
